// File: rtl/decoder_pkg.sv
// Shared definitions for the buffered 3-to-8 one-hot decoder.
// Holds the code/output widths, the replay FSM state type and the
// code-to-one-hot helper used by the decode register.
package decoder_pkg;

    // Width of an incoming code and of the decoded one-hot word.
    localparam int CODE_W = 3;
    localparam int OUT_W  = 8;

    // Replay FSM: wait for a queued code, drive it, then blank the output.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Convert a binary code into its one-hot word (code 0 -> bit 0).
    function automatic logic [OUT_W-1:0] decode_code(input logic [CODE_W-1:0] code);
        logic [OUT_W-1:0] word;
        word = '0;
        word[code] = 1'b1;
        return word;
    endfunction

    // Larger of two integers, used to size the shared hold/gap counter.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/onehot_decoder_sync_fifo.sv
// Reusable synchronous FIFO with show-ahead read data.
// The head entry is always visible on rd_data while empty is low, so a
// consumer can use the data in the same cycle it asserts rd_en.
// Occupancy is tracked with a counter that spans 0..DEPTH, which keeps
// full and empty unambiguous even though the pointers wrap modulo DEPTH.
module sync_fifo #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] count;
    logic             do_wr;
    logic             do_rd;

    // Requests are qualified locally so a careless caller cannot overrun
    // or underrun the storage.
    always_comb begin
        do_wr = wr_en && !full;
        do_rd = rd_en && !empty;
    end

    // Pointers and occupancy; a simultaneous write and read leaves the
    // count unchanged while both pointers advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + LVL_W'(1);
                2'b01:   count <= count - LVL_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Status flags and show-ahead head entry.
    always_comb begin
        full    = (count == LVL_W'(DEPTH));
        empty   = (count == '0);
        level   = count;
        rd_data = mem[rd_ptr];
    end

endmodule

// File: rtl/onehot_decoder.sv
// Buffered 3-to-8 one-hot decoder, the receiving end of the encoder link.
// Codes arrive over a valid/ready handshake into a small FIFO. A three
// state FSM replays each code as a one-hot strobe held for HOLD_CYCLES,
// then drives GAP_CYCLES of zeros so back-to-back codes stay separable.
// Every output is registered and cleared immediately by the async reset.
module onehot_decoder
    import decoder_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 2,
    parameter int GAP_CYCLES  = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [CODE_W-1:0]          in_code,
    output logic [OUT_W-1:0]           out_onehot,
    output logic                       out_valid,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] fifo_level
);

    // One counter serves both the hold and the gap phase, so it is sized
    // for whichever of the two is longer.
    localparam int MAX_CNT = max_int(HOLD_CYCLES, GAP_CYCLES);
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam bit               HAS_GAP   = (GAP_CYCLES > 0);

    state_t              state;
    state_t              state_next;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_next;
    logic [OUT_W-1:0]    word_q;
    logic                valid_q;
    logic                push;
    logic                pop;
    logic [CODE_W-1:0]   head_code;
    logic                fifo_full;
    logic                fifo_empty;

    // Accept only when not full; a pop in the same cycle does not open a
    // slot early, so in_ready depends on the registered full flag alone.
    always_comb begin
        in_ready = !fifo_full;
        push     = in_valid && !fifo_full;
    end

    sync_fifo #(
        .WIDTH (CODE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_data (in_code),
        .rd_en   (pop),
        .rd_data (head_code),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    // The head is consumed only from IDLE, which is why every word costs
    // one extra cycle on top of the hold and gap phases.
    always_comb begin
        pop = (state == IDLE) && !fifo_empty;
    end

    // Next-state and counter logic for the replay sequence.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    state_next = HOLD;
                    cnt_next   = HOLD_LOAD;
                end
            end
            HOLD: begin
                if (cnt == '0) begin
                    if (HAS_GAP) begin
                        state_next = GAP;
                        cnt_next   = GAP_LOAD;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt == '0) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Decode register: loaded on the pop, cleared as the hold phase ends,
    // so the word is never visible outside HOLD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q  <= '0;
            valid_q <= 1'b0;
        end else if (pop) begin
            word_q  <= decode_code(head_code);
            valid_q <= 1'b1;
        end else if (state_next != HOLD) begin
            word_q  <= '0;
            valid_q <= 1'b0;
        end
    end

    // Output drive; busy covers both an active replay and queued codes.
    always_comb begin
        out_onehot = word_q;
        out_valid  = valid_q;
        busy       = (state != IDLE) || !fifo_empty;
    end

endmodule

// File: tb/tb_onehot_decoder.sv
// Self-checking bench for onehot_decoder.
// Stimulus pushes codes and queues the expected one-hot words; a monitor
// on the falling edge pops and compares each word as out_valid rises,
// and also tracks hold length, blanking and the replay period.
// A second instance with HOLD=1, GAP=0 is checked against a cycle table.
module tb_onehot_decoder;
    import decoder_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid;
    logic [2:0] in_code;
    logic       in_ready;
    logic [7:0] out_onehot;
    logic       out_valid;
    logic       busy;
    logic [2:0] fifo_level;

    logic       f_in_valid;
    logic [2:0] f_in_code;
    logic       f_in_ready;
    logic [7:0] f_out_onehot;
    logic       f_out_valid;
    logic       f_busy;
    logic [2:0] f_fifo_level;

    int         vectors     = 0;
    int         miscompares = 0;
    logic [7:0] sb [$];
    int         cycle       = 0;
    bit         check_period = 1'b0;
    int         last_rise    = -1;
    int         hold_len     = 0;
    bit         prev_valid   = 1'b0;

    // Free-running clock.
    always #5 clk = ~clk;

    // Cycle counter used to measure the replay period.
    always @(posedge clk) cycle++;

    onehot_decoder #(
        .DEPTH       (4),
        .HOLD_CYCLES (2),
        .GAP_CYCLES  (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_code    (in_code),
        .out_onehot (out_onehot),
        .out_valid  (out_valid),
        .busy       (busy),
        .fifo_level (fifo_level)
    );

    onehot_decoder #(
        .DEPTH       (4),
        .HOLD_CYCLES (1),
        .GAP_CYCLES  (0)
    ) dut_fast (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (f_in_valid),
        .in_ready   (f_in_ready),
        .in_code    (f_in_code),
        .out_onehot (f_out_onehot),
        .out_valid  (f_out_valid),
        .busy       (f_busy),
        .fifo_level (f_fifo_level)
    );

    // One comparison: counts it and reports a mismatch.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Offer one code from a falling edge, wait for in_ready, and queue the
    // word the decoder should later replay for it.
    task automatic applyStimulus(input logic [2:0] code, input logic [7:0] expected);
        int waited;
        waited   = 0;
        in_valid = 1'b1;
        in_code  = code;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL accept_timeout: code %0d never accepted", code);
        end else begin
            sb.push_back(expected);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_code  = 'x;
    endtask

    // Wait, with a bound, until the main decoder has drained everything.
    task automatic waitIdle();
        int n;
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL idle_timeout: busy still 1 after %0d cycles", n);
        end
        @(negedge clk);
    endtask

    // Model of the 8-to-3 encoder on the other end of the link.
    function automatic logic [2:0] encode(input logic [7:0] x);
        logic [2:0] code;
        code = '0;
        for (int b = 0; b < 8; b++) begin
            if (x[b]) code = b[2:0];
        end
        return code;
    endfunction

    // Monitor: scoreboard pop on each new word plus per-cycle invariants.
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
            hold_len   = 0;
        end else begin
            if (out_valid) begin
                checkOutput("onehot_bits", $countones(out_onehot), 1);
                if (!prev_valid) begin
                    if (sb.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("[TB] FAIL unexpected_word: got 0x%0h, expected no output", out_onehot);
                    end else begin
                        checkOutput("sb_word", out_onehot, sb.pop_front());
                    end
                    if (check_period && last_rise >= 0) begin
                        checkOutput("period", cycle - last_rise, 4);
                    end
                    last_rise = cycle;
                    hold_len  = 1;
                end else begin
                    hold_len++;
                end
            end else begin
                checkOutput("zero_when_invalid", out_onehot, 8'h00);
                if (prev_valid) begin
                    checkOutput("hold_len", hold_len, 2);
                end
            end
            prev_valid = out_valid;
        end
    end

    // Global time limit.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test sequence.
    initial begin
        logic [7:0] t1_exp [8];
        logic [7:0] x;
        logic [7:0] f_exp_w [7];
        logic       f_exp_v [7];

        t1_exp  = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
        f_exp_v = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        f_exp_w = '{8'h00, 8'h04, 8'h00, 8'h20, 8'h00, 8'h80, 8'h00};

        in_valid   = 1'b0;
        in_code    = '0;
        f_in_valid = 1'b0;
        f_in_code  = '0;

        #1 rst = 1'b1;
        #2;
        $display("[TB] reset state");
        checkOutput("rst_onehot", out_onehot, 8'h00);
        checkOutput("rst_valid", out_valid, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_level", fifo_level, 3'd0);
        checkOutput("rst_ready", in_ready, 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] single codes 0..7");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(i[2:0], t1_exp[i]);
            checkOutput("latency_pre", out_valid, 1'b0);
            @(negedge clk);
            checkOutput("latency_valid", out_valid, 1'b1);
            checkOutput("latency_word", out_onehot, t1_exp[i]);
            waitIdle();
        end

        $display("[TB] encoder round trip");
        for (int i = 0; i < 8; i++) begin
            x = 8'h01 << i;
            applyStimulus(encode(x), x);
        end
        waitIdle();

        $display("[TB] burst 5,1,6,2,7 and push against full");
        last_rise    = -1;
        check_period = 1'b1;
        applyStimulus(3'd5, 8'h20);
        applyStimulus(3'd1, 8'h02);
        applyStimulus(3'd6, 8'h40);
        applyStimulus(3'd2, 8'h04);
        applyStimulus(3'd7, 8'h80);
        checkOutput("burst_level", fifo_level, 3'd4);
        checkOutput("burst_ready", in_ready, 1'b0);
        in_valid = 1'b1;
        in_code  = 3'd4;
        @(negedge clk);
        in_valid = 1'b0;
        in_code  = 'x;
        checkOutput("reject_level", fifo_level, 3'd3);
        checkOutput("reject_ready", in_ready, 1'b1);
        waitIdle();
        check_period = 1'b0;

        $display("[TB] reset during hold");
        applyStimulus(3'd3, 8'h08);
        applyStimulus(3'd6, 8'h40);
        applyStimulus(3'd1, 8'h02);
        checkOutput("pre_rst_valid", out_valid, 1'b1);
        checkOutput("pre_rst_level", fifo_level, 3'd2);
        rst = 1'b1;
        #1;
        sb.delete();
        checkOutput("mid_rst_onehot", out_onehot, 8'h00);
        checkOutput("mid_rst_valid", out_valid, 1'b0);
        checkOutput("mid_rst_level", fifo_level, 3'd0);
        checkOutput("mid_rst_busy", busy, 1'b0);
        checkOutput("mid_rst_ready", in_ready, 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("post_rst_busy", busy, 1'b0);
        checkOutput("post_rst_valid", out_valid, 1'b0);

        $display("[TB] HOLD=1 GAP=0 back-to-back");
        f_in_valid = 1'b1;
        f_in_code  = 3'd2;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            checkOutput("fast_valid", f_out_valid, f_exp_v[k]);
            checkOutput("fast_word", f_out_onehot, f_exp_w[k]);
            if (k == 0) f_in_code = 3'd5;
            if (k == 1) f_in_code = 3'd7;
            if (k == 2) begin
                f_in_valid = 1'b0;
                f_in_code  = 'x;
            end
        end
        repeat (2) @(negedge clk);
        checkOutput("fast_idle", f_busy, 1'b0);

        checkOutput("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
